// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate formats, bubble word.
// Also holds the decode -> execute bundle type.
package decode_pkg;

  localparam logic [31:0] NOP_VALUE = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        illegal;
  } id_ex_t;

  function automatic imm_fmt_t fmt_of(logic [6:0] op);
    imm_fmt_t f;
    f = FMT_NONE;
    unique case (1'b1)
      (op == OP_OP):     f = FMT_R;
      (op == OP_IMM),
      (op == OP_LOAD),
      (op == OP_JALR),
      (op == OP_FENCE),
      (op == OP_SYSTEM): f = FMT_I;
      (op == OP_STORE):  f = FMT_S;
      (op == OP_BRANCH): f = FMT_B;
      (op == OP_LUI),
      (op == OP_AUIPC):  f = FMT_U;
      (op == OP_JAL):    f = FMT_J;
      default:           f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch/execute/writeback signals seen by the decode stage.
// master drives stage inputs, slave is the decode stage itself.
interface decode_if;
  logic        stall_in;
  logic        flush;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        illegal;

  modport master (
    output stall_in, flush, pc_in, instruction_in,
    output wb_en, wb_rd, wb_data, ex_mem_read, ex_rd,
    input  stall_out, valid_out, pc_out, opcode, funct3,
    input  funct7_5, rd, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, imm, illegal
  );

  modport slave (
    input  stall_in, flush, pc_in, instruction_in,
    input  wb_en, wb_rd, wb_data, ex_mem_read, ex_rd,
    output stall_out, valid_out, pc_out, opcode, funct3,
    output funct7_5, rd, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, imm, illegal
  );
endinterface

// File: rtl/decode_regfile.sv
// 32x32 integer register file: two async reads, one sync write.
// x0 is hardwired to zero; reset clears every entry.
module decode_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] mem [32];

  // clear on reset, otherwise commit writeback to nonzero registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : mem[ra2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field split, operand read, immediates, load-use stall.
// DECODE_WB_BYPASS_EN forwards same-cycle writeback instead of stalling.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = NOP_VALUE
) (
  input  logic    clk,
  input  logic    rst,
  decode_if.slave dec
);

  logic [31:0] insn;
  logic [4:0]  ra1, ra2;
  logic [31:0] rf1, rf2, src1, src2;
  imm_fmt_t    fmt;
  logic        use1, use2;
  logic        ld1, ld2, wb1, wb2, hz1, hz2;
  logic        wb_live, stall;
  id_ex_t      cap, bub, q;

  function automatic logic [31:0] gen_imm(logic [31:0] w);
    logic [31:0] v;
    v = '0;
    unique case (fmt_of(w[6:0]))
      FMT_I: v = {{20{w[31]}}, w[31:20]};
      FMT_S: v = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B: v = {{20{w[31]}}, w[7], w[30:25],
                  w[11:8], 1'b0};
      FMT_U: v = {w[31:12], 12'h000};
      FMT_J: v = {{12{w[31]}}, w[19:12], w[20],
                  w[30:21], 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

  assign insn = dec.instruction_in;
  assign ra1  = insn[19:15];
  assign ra2  = insn[24:20];
  assign fmt  = fmt_of(insn[6:0]);
  assign use1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign use2 = fmt inside {FMT_R, FMT_S, FMT_B};

  decode_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .we  (dec.wb_en),
    .wa  (dec.wb_rd),
    .wd  (dec.wb_data),
    .ra1 (ra1),
    .ra2 (ra2),
    .rd1 (rf1),
    .rd2 (rf2)
  );

  assign wb_live = dec.wb_en && dec.wb_rd != 5'd0;
  assign wb1 = wb_live && dec.wb_rd == ra1;
  assign wb2 = wb_live && dec.wb_rd == ra2;
  assign ld1 = dec.ex_mem_read && dec.ex_rd != 5'd0
            && dec.ex_rd == ra1;
  assign ld2 = dec.ex_mem_read && dec.ex_rd != 5'd0
            && dec.ex_rd == ra2;

`ifdef DECODE_WB_BYPASS_EN
  assign src1 = wb1 ? dec.wb_data : rf1;
  assign src2 = wb2 ? dec.wb_data : rf2;
  assign hz1  = ld1;
  assign hz2  = ld2;
`else
  assign src1 = rf1;
  assign src2 = rf2;
  assign hz1  = ld1 || wb1;
  assign hz2  = ld2 || wb2;
`endif

  assign stall = !dec.flush
              && ((use1 && hz1) || (use2 && hz2));
  assign dec.stall_out = stall;

  // decoded view of the incoming instruction
  always_comb begin
    cap          = '0;
    cap.valid    = 1'b1;
    cap.pc       = dec.pc_in;
    cap.opcode   = insn[6:0];
    cap.funct3   = insn[14:12];
    cap.funct7_5 = insn[30];
    cap.rd       = insn[11:7];
    cap.rs1_addr = ra1;
    cap.rs2_addr = ra2;
    cap.rs1_data = src1;
    cap.rs2_data = src2;
    cap.imm      = gen_imm(insn);
    cap.illegal  = (fmt == FMT_NONE);
  end

  // bubble: NOP fields, zero operands, pc kept
  always_comb begin
    bub          = '0;
    bub.pc       = q.pc;
    bub.opcode   = NOP_INSN[6:0];
    bub.funct3   = NOP_INSN[14:12];
    bub.funct7_5 = NOP_INSN[30];
    bub.rd       = NOP_INSN[11:7];
    bub.rs1_addr = NOP_INSN[19:15];
    bub.rs2_addr = NOP_INSN[24:20];
    bub.imm      = gen_imm(NOP_INSN);
  end

  // stage register: reset, then flush, then hold, then stall bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= bub;
      q.pc  <= '0;
      q.imm <= '0;
    end else if (dec.flush) begin
      q <= bub;
    end else if (!dec.stall_in) begin
      q <= stall ? bub : cap;
    end
  end

  assign dec.valid_out = q.valid;
  assign dec.pc_out    = q.pc;
  assign dec.opcode    = q.opcode;
  assign dec.funct3    = q.funct3;
  assign dec.funct7_5  = q.funct7_5;
  assign dec.rd        = q.rd;
  assign dec.rs1_addr  = q.rs1_addr;
  assign dec.rs2_addr  = q.rs2_addr;
  assign dec.rs1_data  = q.rs1_data;
  assign dec.rs2_data  = q.rs2_data;
  assign dec.imm       = q.imm;
  assign dec.illegal   = q.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter NOP_INSN, default 32'h00000013, bubble instruction (addi x0,x0,0) loaded on flush/reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 stall_in  input  1  downstream hold; freezes all stage registers.
REQ-005 flush  input  1  branch-taken kill of the instruction being captured.
REQ-006 pc_in, instruction_in  input  32 each  fetch-stage pc_out and instruction_out.
REQ-007 wb_en, wb_rd, wb_data  input  1/5/32  writeback port.
REQ-008 ex_mem_read, ex_rd  input  1/5  load currently in execute, and its destination.
REQ-009 stall_out  output  1  combinational hold request to fetch stall input.
REQ-010 valid_out, pc_out  output  1/32  registered slot valid and pc.
REQ-011 opcode, funct3, funct7_5, rd, rs1_addr, rs2_addr  output  7/3/1/5/5/5  registered fields.
REQ-012 rs1_data, rs2_data, imm  output  32 each  registered operands and sign-extended immediate.
REQ-013 illegal  output  1  registered; opcode not in RV32I base set.

Function
REQ-014 Latency one cycle: instruction_in at edge N appears decoded on outputs after edge N.
REQ-015 Capture when !stall_in && !stall_out; otherwise all output registers hold.
REQ-016 Register file 32x32, combinational read using instruction_in rs1/rs2 fields at capture.
REQ-017 x0 reads 0; writes with wb_rd==0 ignored.
REQ-018 imm per format: I, S, B (bit0=0), U (low 12 zero), J (bit0=0); R-type imm=0.
REQ-019 Load-use: stall_out=1 when ex_mem_read && ex_rd!=0 && ex_rd matches a source used by instruction_in's format.
REQ-020 While stall_out=1 and !stall_in: capture bubble (valid_out=0, NOP_INSN fields, pc_out held).
REQ-021 flush=1: next cycle valid_out=0, fields decoded from NOP_INSN; flush overrides stall_in and stall_out.
REQ-022 stall_out forced 0 when flush=1.
REQ-023 Writeback commits every cycle wb_en=1, independent of stall_in/stall_out/flush.
REQ-024 illegal only meaningful when valid_out=1; forced 0 on bubbles.

Reset
REQ-025 rst=1 at posedge: valid_out=0, pc_out=0, fields from NOP_INSN, rs data=0, imm=0, illegal=0.
REQ-026 All 32 registers cleared to 0 under rst; writeback ignored that cycle.
REQ-027 rst mid-stall or mid-flush dominates; stage empty next cycle.

Configuration
REQ-028 Macro DECODE_WB_BYPASS_EN defined: read of register equal to wb_rd (nonzero, wb_en=1) same cycle returns wb_data.
REQ-029 Macro undefined: such a read raises stall_out for one cycle; operand read after commit.

Structure
REQ-030 Shared package decode_pkg: RV32I opcode constants, imm-format enum, NOP_INSN value.
REQ-031 One sub-module decode_regfile: 2 async read ports, 1 sync write port, reset clear.
REQ-032 Immediate generation and hazard compare are combinational logic inside decode_stage.

Verification
REQ-033 rst, then addi x1,x0,5 (32'h00500093) pc 0x314 -> next cycle valid_out=1, rd=1, imm=5, pc_out=0x314.
REQ-034 wb x2=0xDEADBEEF, then add x3,x2,x2 -> rs1_data=rs2_data=0xDEADBEEF; same-cycle with bypass: no stall, without: stall_out 1 cycle.
REQ-035 ex_mem_read=1, ex_rd=4, instruction_in uses rs1=4 -> stall_out=1, next valid_out=0; ex_rd=0 -> no stall.
REQ-036 flush=1 with stall_in=1 -> next cycle valid_out=0, opcode=7'h13.
REQ-037 beq imm -8 and jal imm +2048 -> imm=32'hFFFFFFF8 and 32'h00000800; opcode 7'h7F -> illegal=1.
